note_tone_gen: RTL and testbench



---
 rtl/note_pkg.sv | 35 +++
 rtl/note_tone_gen_square_osc.sv | 57 +++++
 rtl/note_tone_gen.sv | 103 ++++++++++
 tb/tb_note_tone_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Note codes, half-period table and envelope state type shared by the tone generator.
// Half-periods are in CLOCK_50 cycles; code-to-period lookup returns 0 for silence codes.
package note_pkg;

   localparam int unsigned HP_W  = 17;
   localparam int unsigned AMP_W = 24;

   localparam logic [2:0] NOTE_C4 = 3'b001;
   localparam logic [2:0] NOTE_D4 = 3'b010;
   localparam logic [2:0] NOTE_E4 = 3'b100;
   localparam logic [2:0] NOTE_F4 = 3'b110;
   localparam logic [2:0] NOTE_G4 = 3'b011;

   localparam logic [HP_W-1:0] HP_C4 = 17'd95554;
   localparam logic [HP_W-1:0] HP_D4 = 17'd85133;
   localparam logic [HP_W-1:0] HP_E4 = 17'd75843;
   localparam logic [HP_W-1:0] HP_F4 = 17'd71586;
   localparam logic [HP_W-1:0] HP_G4 = 17'd63776;

   typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

   function automatic logic [HP_W-1:0] half_period(input logic [2:0] code);
      logic [HP_W-1:0] hp;
      case (code)
         NOTE_C4: hp = HP_C4;
         NOTE_D4: hp = HP_D4;
         NOTE_E4: hp = HP_E4;
         NOTE_F4: hp = HP_F4;
         NOTE_G4: hp = HP_G4;
         default: hp = '0;
      endcase
      return hp;
   endfunction

endpackage

// File: rtl/note_tone_gen_square_osc.sv
// Square-wave polarity source: half-period counter that retunes on a new tone code,
// keeps the last pitch through silence, and is cleared once the release has finished.
module square_osc
   import note_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [2:0] note_i,
   input  logic       clear_i,
   output logic       neg_o
);

   logic [HP_W-1:0] period_q, period_d;
   logic [HP_W-1:0] hp_cnt_q, hp_cnt_d;
   logic            neg_q, neg_d;
   logic [HP_W-1:0] hp_new;

   assign hp_new = half_period(note_i);

   always_comb begin
      period_d = period_q;
      hp_cnt_d = hp_cnt_q;
      neg_d    = neg_q;
      if (clear_i) begin
         period_d = '0;
         hp_cnt_d = '0;
         neg_d    = 1'b0;
      end else if (hp_new != '0 && hp_new != period_q) begin
         // a retune restarts the waveform on a positive half, overriding any wrap this cycle
         period_d = hp_new;
         hp_cnt_d = '0;
         neg_d    = 1'b0;
      end else if (period_q != '0) begin
         if (hp_cnt_q == period_q - 17'd1) begin
            hp_cnt_d = '0;
            neg_d    = ~neg_q;
         end else begin
            hp_cnt_d = hp_cnt_q + 17'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         period_q <= '0;
         hp_cnt_q <= '0;
         neg_q    <= 1'b0;
      end else begin
         period_q <= period_d;
         hp_cnt_q <= hp_cnt_d;
         neg_q    <= neg_d;
      end
   end

   assign neg_o = neg_q;

endmodule

// File: rtl/note_tone_gen.sv
// Note-code driven square-wave tone with linear attack/release envelope, streamed mono
// to the codec FIFO at most every other cycle while audio_out_allowed is high.
module note_tone_gen
   import note_pkg::*;
#(
   parameter logic [AMP_W-1:0] AMP_MAX   = 24'h3FFFFF,
   parameter logic [AMP_W-1:0] RAMP_STEP = 24'd4096,
   parameter int unsigned      SAMPLE_W  = 32
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic [2:0]          note,
   input  logic                audio_out_allowed,
   output logic                write_audio_out,
   output logic [SAMPLE_W-1:0] left_channel_audio_out,
   output logic [SAMPLE_W-1:0] right_channel_audio_out,
   output logic                busy
);

   logic [2:0]          note_q;
   logic                allowed_q;
   logic                wr_q, wr_d;
   env_state_t          state_q, state_d;
   logic [AMP_W-1:0]    amp_q, amp_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic                tone;
   logic                release_done;
   logic                neg;
   logic [AMP_W:0]      amp_sum;
   logic [AMP_W-1:0]    amp_up, amp_dn;
   logic [SAMPLE_W-1:0] mag;

   assign tone    = (half_period(note_q) != '0);
   assign amp_sum = {1'b0, amp_q} + {1'b0, RAMP_STEP};
   assign amp_up  = (amp_sum > {1'b0, AMP_MAX}) ? AMP_MAX : amp_sum[AMP_W-1:0];
   assign amp_dn  = (amp_q > RAMP_STEP) ? (amp_q - RAMP_STEP) : '0;

   // amp moves only in a strobe cycle, always by the rule of the state being left
   always_comb begin
      state_d      = state_q;
      amp_d        = amp_q;
      release_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (tone) state_d = ATTACK;
         end
         ATTACK: begin
            if (wr_q) amp_d = amp_up;
            if (!tone) state_d = RELEASE;
            else if (wr_q && amp_up == AMP_MAX) state_d = SUSTAIN;
         end
         SUSTAIN: begin
            if (!tone) state_d = RELEASE;
         end
         RELEASE: begin
            if (wr_q) amp_d = amp_dn;
            if (tone) begin
               state_d = ATTACK;
            end else if (wr_q && amp_dn == '0) begin
               state_d      = IDLE;
               release_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign wr_d     = allowed_q & ~wr_q;
   assign mag      = {{(SAMPLE_W-AMP_W){1'b0}}, amp_q};
   assign sample_d = neg ? (~mag + 1'b1) : mag;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         note_q    <= '0;
         allowed_q <= 1'b0;
         wr_q      <= 1'b0;
         state_q   <= IDLE;
         amp_q     <= '0;
         sample_q  <= '0;
      end else begin
         note_q    <= note;
         allowed_q <= audio_out_allowed;
         wr_q      <= wr_d;
         state_q   <= state_d;
         amp_q     <= amp_d;
         if (wr_d) sample_q <= sample_d;
      end
   end

   square_osc u_osc (
      .clk_i   (CLOCK_50),
      .rst_ni  (resetn),
      .note_i  (note_q),
      .clear_i (release_done),
      .neg_o   (neg)
   );

   assign write_audio_out         = wr_q;
   assign left_channel_audio_out  = sample_q;
   assign right_channel_audio_out = sample_q;
   assign busy                    = (state_q != IDLE);

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen: envelope ramps, retune timing, handshake pacing, reset and silence codes.
module tb_note_tone_gen;

   localparam int unsigned AMP_MAX = 32'h3FFFFF;
   localparam int unsigned STEP    = 4096;

   logic        CLOCK_50 = 1'b0;
   logic        resetn   = 1'b0;
   logic [2:0]  note     = 3'b000;
   logic        allowed  = 1'b0;
   logic        wr;
   logic [31:0] left, right;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int lr_bad = 0;

   always #10 CLOCK_50 = ~CLOCK_50;

   note_tone_gen dut (
      .CLOCK_50                (CLOCK_50),
      .resetn                  (resetn),
      .note                    (note),
      .audio_out_allowed       (allowed),
      .write_audio_out         (wr),
      .left_channel_audio_out  (left),
      .right_channel_audio_out (right),
      .busy                    (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask

   task automatic next_strobe(output logic [31:0] s);
      for (int i = 0; i < 8; i++) begin
         @(negedge CLOCK_50);
         if (wr === 1'b1) begin
            s = left;
            if (right !== left) lr_bad++;
            return;
         end
      end
      s = '0;
      checks++;
      errors++;
      $error("FAIL strobe_timeout: no write_audio_out within 8 cycles");
   endtask

   function automatic int unsigned mag(input logic [31:0] s);
      logic [31:0] neg_s;
      neg_s = ~s + 32'd1;
      return s[31] ? neg_s : s;
   endfunction

   initial begin
      logic [31:0] s;
      int unsigned m, prev, want, cnt, bad, negs, nz, strobes, held, mmin, first_neg;

      // reset state
      repeat (3) @(negedge CLOCK_50);
      check("rst_wr", wr, 0);
      check("rst_left", left, 0);
      check("rst_right", right, 0);
      check("rst_busy", busy, 0);
      allowed = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      check("rst_hold_wr", wr, 0);
      resetn = 1'b1;
      @(negedge CLOCK_50);
      check("first_strobe_gap", wr, 0);

      // idle streaming of zeros, one strobe every second cycle
      strobes = 0; bad = 0;
      repeat (20) begin
         @(negedge CLOCK_50);
         if (wr) begin
            strobes++;
            if (left != 0) bad++;
         end
      end
      check("idle_strobes", strobes, 10);
      check("idle_zero", bad, 0);
      check("idle_busy", busy, 0);

      // C4 attack from zero to AMP_MAX
      next_strobe(s);
      note = 3'b001;
      nz = 0; bad = 0; negs = 0; prev = 0; m = 0;
      for (int i = 0; i < 1200; i++) begin
         next_strobe(s);
         m = mag(s);
         if (s[31]) negs++;
         if (m != 0) begin
            nz++;
            want = (prev + STEP > AMP_MAX) ? AMP_MAX : prev + STEP;
            if (m != want) bad++;
            prev = m;
            if (m == AMP_MAX) break;
         end
      end
      check("attack_peak", m, AMP_MAX);
      check("attack_strobes", nz, 1024);
      check("attack_steps", bad, 0);
      check("attack_sign", negs, 0);
      check("attack_busy", busy, 1);
      repeat (4) next_strobe(s);
      check("sustain_hold", s, AMP_MAX);

      // retune C4 -> G4 in sustain; first negative sample lands on edge 63780
      next_strobe(s);
      note = 3'b011;
      first_neg = 0;
      for (int i = 1; i <= 70000; i++) begin
         @(negedge CLOCK_50);
         if (i == 4) begin
            check("g4_switch_amp", left, AMP_MAX);
            check("g4_switch_busy", busy, 1);
         end
         if (left[31]) begin
            first_neg = i;
            break;
         end
      end
      check("g4_half_period", first_neg, 63780);

      // release at G4 pitch down to zero
      note = 3'b000;
      prev = AMP_MAX; cnt = 0; bad = 0; negs = 0; m = AMP_MAX;
      for (int i = 0; i < 1200; i++) begin
         next_strobe(s);
         m = mag(s);
         if (m < AMP_MAX) begin
            cnt++;
            want = (prev >= STEP) ? prev - STEP : 0;
            if (m != want) bad++;
            if (m != 0 && !s[31]) negs++;
            prev = m;
            if (m == 0) break;
         end
      end
      check("release_floor", m, 0);
      check("release_strobes", cnt, 1024);
      check("release_steps", bad, 0);
      check("release_sign", negs, 0);
      check("release_idle", busy, 0);

      // backpressure: no strobes and frozen sample while not allowed
      next_strobe(s);
      note = 3'b001;
      repeat (10) next_strobe(s);
      allowed = 1'b0;
      repeat (4) @(negedge CLOCK_50);
      held = left;
      strobes = 0; bad = 0;
      repeat (30) begin
         @(negedge CLOCK_50);
         if (wr) strobes++;
         if (left != held) bad++;
      end
      check("pause_strobes", strobes, 0);
      check("pause_hold", bad, 0);
      allowed = 1'b1;
      next_strobe(s);
      check("pause_resume", mag(s), held + STEP);

      m = 0;
      for (int i = 0; i < 1200; i++) begin
         next_strobe(s);
         m = mag(s);
         if (m == AMP_MAX) break;
      end
      check("attack2_peak", m, AMP_MAX);

      // reassert a tone mid-release: attack resumes from the current amplitude
      note = 3'b000;
      for (int i = 0; i < 1200; i++) begin
         next_strobe(s);
         m = mag(s);
         if (m <= 32'h200000) break;
      end
      note = 3'b010;
      mmin = m; prev = m; cnt = 0; bad = 0;
      for (int i = 0; i < 1200; i++) begin
         next_strobe(s);
         m = mag(s);
         if (m < mmin) begin
            mmin = m; prev = m; cnt = 0;
         end else begin
            cnt++;
            want = (prev + STEP > AMP_MAX) ? AMP_MAX : prev + STEP;
            if (m != want) bad++;
            prev = m;
            if (m == AMP_MAX) break;
         end
      end
      check("resume_no_zero", mmin > 32'h1F0000, 1);
      check("resume_steps", bad, 0);
      check("resume_peak", m, AMP_MAX);
      check("resume_strobes", cnt, (AMP_MAX - mmin + STEP - 1) / STEP);

      // asynchronous reset in the middle of an attack
      note = 3'b000;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLOCK_50);
         if (!busy) break;
      end
      check("release2_idle", busy, 0);
      note = 3'b001;
      repeat (20) next_strobe(s);
      check("pre_reset_busy", busy, 1);
      resetn = 1'b0;
      #1;
      check("arst_wr", wr, 0);
      check("arst_left", left, 0);
      check("arst_right", right, 0);
      check("arst_busy", busy, 0);

      // silence codes 101 and 111
      note = 3'b101;
      repeat (2) @(negedge CLOCK_50);
      resetn = 1'b1;
      strobes = 0; nz = 0; bad = 0;
      repeat (40) begin
         @(negedge CLOCK_50);
         if (wr) strobes++;
         if (left != 0) nz++;
         if (busy) bad++;
      end
      check("code101_strobes", strobes, 20);
      check("code101_zero", nz, 0);
      check("code101_busy", bad, 0);
      note = 3'b111;
      strobes = 0; nz = 0; bad = 0;
      repeat (40) begin
         @(negedge CLOCK_50);
         if (wr) strobes++;
         if (left != 0) nz++;
         if (busy) bad++;
      end
      check("code111_strobes", strobes, 20);
      check("code111_zero", nz, 0);
      check("code111_busy", bad, 0);
      note = 3'b100;
      repeat (3) @(negedge CLOCK_50);
      check("e4_busy", busy, 1);

      check("left_eq_right", lr_bad, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
